// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram line scheduler.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
// Contents: board geometry constants, line/option index types, FSM state
// enum, popcount class codes and first_alive(), which finds the lowest set
// bit of an alive mask at or above a starting index.
package nonogram_pkg;

  localparam int NG_SIZE     = 4;
  localparam int NG_MAX_OPTS = 16;
  localparam int IND_W       = $clog2(NG_SIZE);
  localparam int LINE_W      = 1 + IND_W;
  localparam int OPT_W       = $clog2(NG_MAX_OPTS);
  localparam int NUM_LINES   = 2 * NG_SIZE;

  typedef logic [LINE_W-1:0]      line_id_t;  // {row, ind}
  typedef logic [OPT_W-1:0]       opt_idx_t;
  typedef logic [NG_MAX_OPTS-1:0] opt_mask_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_POP, ST_LOAD, ST_FETCH, ST_CHECK,
    ST_DECIDE, ST_REQUEUE, ST_COMMIT, ST_DONE, ST_STUCK
  } state_t;

  // Saturating popcount classes
  localparam logic [1:0] PC_NONE = 2'd0;
  localparam logic [1:0] PC_ONE  = 2'd1;
  localparam logic [1:0] PC_MANY = 2'd2;

  typedef struct packed {
    logic     found;
    opt_idx_t idx;
  } alive_sel_t;

  // 'from' is one bit wider than an option index so that "past the last
  // option" is representable and simply yields found = 0.
  function automatic alive_sel_t first_alive(opt_mask_t mask, logic [OPT_W:0] from);
    alive_sel_t r;
    r = '0;
    for (int i = NG_MAX_OPTS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = opt_idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nonogram_line_scheduler_popcount_sat.sv
// Saturating popcount of an alive mask: 0, 1 or "2 or more".
// Latency: combinational.
// Backpressure: none.
// Ports: mask (W bits) in; cnt out, one of PC_NONE / PC_ONE / PC_MANY.
module popcount_sat
  import nonogram_pkg::*;
#(
  parameter int W = NG_MAX_OPTS
) (
  input  logic [W-1:0] mask,
  output logic [1:0]   cnt
);

  always_comb begin
    cnt = PC_NONE;
    for (int i = 0; i < W; i++) begin
      if (mask[i]) cnt = (cnt == PC_NONE) ? PC_ONE : PC_MANY;
    end
  end

endmodule

// File: rtl/nonogram_line_scheduler.sv
// Pops lines, checks every alive option, then commits, requeues or stops.
// Latency: per line 2 + 3k + 1 cycles (k alive options), +2 commit / +>=1 requeue.
// Backpressure: holds in REQUEUE while q_full; holds in CHECK until chk_valid.
// Ports: start/cnt_* from the loader; q_* line queue handshake; rom_addr/
// rom_data synchronous option ROM; chk_* line checker; commit_* board write;
// busy/done/stuck status (done/stuck sticky until rst or start).
module nonogram_line_scheduler
  import nonogram_pkg::*;
#(
  parameter int SIZE     = NG_SIZE,
  parameter int MAX_OPTS = NG_MAX_OPTS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   cnt_we,
  input  logic [$clog2(SIZE):0]                  cnt_line,
  input  logic [$clog2(MAX_OPTS):0]              cnt_val,
  input  logic                                   q_empty,
  output logic                                   q_rd,
  input  logic [$clog2(SIZE):0]                  q_dout,
  input  logic                                   q_full,
  output logic                                   q_wr,
  output logic [$clog2(SIZE):0]                  q_din,
  output logic [$clog2(SIZE)+$clog2(MAX_OPTS):0] rom_addr,
  input  logic [SIZE-1:0]                        rom_data,
  output logic                                   chk_req,
  output logic                                   chk_row,
  output logic [$clog2(SIZE)-1:0]                chk_ind,
  output logic [SIZE-1:0]                        chk_option,
  input  logic                                   chk_valid,
  input  logic                                   chk_contradict,
  output logic                                   commit,
  output logic                                   commit_row,
  output logic [$clog2(SIZE)-1:0]                commit_ind,
  output logic [SIZE-1:0]                        commit_option,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   stuck
);

  localparam int CNT_W = $clog2(NUM_LINES) + 1;

  state_t          state;
  logic            phase;     // second cycle of CHECK (result) / COMMIT (data)
  line_id_t        cur_line;
  opt_idx_t        opt_idx;
  opt_mask_t       alive [NUM_LINES];
  logic            progress;  // some option eliminated or line committed this pass
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] occ;

  opt_mask_t  cur_mask, cnt_mask, chk_mask;
  alive_sel_t next_sel, load_sel, sole_sel;
  logic [1:0] pc;
  logic       line_fin, fin_prog, fin_reload, fin_stuck;
  logic [CNT_W-1:0] fin_occ;

  popcount_sat #(.W(NG_MAX_OPTS)) u_popcount (
    .mask (cur_mask),
    .cnt  (pc)
  );

  always_comb begin
    cur_mask = alive[cur_line];
    for (int i = 0; i < NG_MAX_OPTS; i++) begin
      cnt_mask[i] = ((OPT_W + 1)'(i) < cnt_val);
    end
    chk_mask = cur_mask;
    if (chk_contradict) chk_mask[opt_idx] = 1'b0;
    next_sel = first_alive(chk_mask, {1'b0, opt_idx} + (OPT_W + 1)'(1));
    load_sel = first_alive(alive[q_dout], '0);
    sole_sel = first_alive(cur_mask, '0);
    // A line finishes when its commit is written or its requeue push lands.
    line_fin   = ((state == ST_COMMIT) && phase) || q_wr;
    fin_prog   = progress || (state == ST_COMMIT);
    fin_occ    = (state == ST_REQUEUE) ? occ + CNT_W'(1) : occ;
    fin_reload = (pass_cnt <= CNT_W'(1));
    fin_stuck  = fin_reload && !fin_prog;
  end

  // Queue strobes are gated by the queue flags in the same cycle so a push
  // lands on the first cycle q_full drops and a pop never hits an empty queue.
  assign q_rd          = (state == ST_POP) && !q_empty;
  assign q_wr          = (state == ST_REQUEUE) && !q_full;
  assign q_din         = q_wr ? cur_line : '0;
  assign rom_addr      = {cur_line, opt_idx};
  assign chk_req       = (state == ST_CHECK) && !phase;
  assign chk_row       = chk_req & cur_line[LINE_W-1];
  assign chk_ind       = chk_req ? cur_line[IND_W-1:0] : '0;
  assign chk_option    = chk_req ? rom_data : '0;
  assign commit        = (state == ST_COMMIT) && phase;
  assign commit_row    = commit & cur_line[LINE_W-1];
  assign commit_ind    = commit ? cur_line[IND_W-1:0] : '0;
  assign commit_option = commit ? rom_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      cur_line <= '0;
      opt_idx  <= '0;
      progress <= 1'b0;
      pass_cnt <= '0;
      occ      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stuck    <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) alive[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_STUCK: begin
          if (cnt_we && (state == ST_IDLE)) alive[cnt_line] <= cnt_mask;
          if (start) begin
            // The loader has queued every line once; occupancy starts there.
            state    <= ST_POP;
            pass_cnt <= CNT_W'(NUM_LINES);
            occ      <= CNT_W'(NUM_LINES);
            progress <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            stuck    <= 1'b0;
          end
        end
        ST_POP: begin
          if (q_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            if (occ != '0) occ <= occ - CNT_W'(1);
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cur_line <= q_dout;
          opt_idx  <= load_sel.idx;
          phase    <= 1'b0;
          state    <= load_sel.found ? ST_FETCH : ST_DECIDE;
        end
        ST_FETCH: begin
          phase <= 1'b0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!phase) begin
            phase <= 1'b1;
          end else if (chk_valid) begin
            phase <= 1'b0;
            if (chk_contradict) begin
              alive[cur_line] <= chk_mask;
              progress        <= 1'b1;
            end
            if (next_sel.found) begin
              opt_idx <= next_sel.idx;
              state   <= ST_FETCH;
            end else begin
              state <= ST_DECIDE;
            end
          end
        end
        ST_DECIDE: begin
          phase <= 1'b0;
          if (pc == PC_NONE) begin
            state <= ST_STUCK;
            stuck <= 1'b1;
            busy  <= 1'b0;
          end else if ((pc == PC_ONE) && sole_sel.found) begin
            opt_idx <= sole_sel.idx;  // refetch the survivor's pattern
            state   <= ST_COMMIT;
          end else begin
            state <= ST_REQUEUE;
          end
        end
        ST_COMMIT:  phase <= ~phase;
        ST_REQUEUE: ;
        default:    state <= ST_IDLE;
      endcase

      // End-of-line pass accounting; overrides the state chosen above.
      if (line_fin) begin
        occ <= fin_occ;
        if (fin_stuck) begin
          state <= ST_STUCK;
          stuck <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state <= ST_POP;
          if (fin_reload) begin
            pass_cnt <= fin_occ;
            progress <= 1'b0;
          end else begin
            pass_cnt <= pass_cnt - CNT_W'(1);
            progress <= fin_prog;
          end
        end
      end
    end
  end

endmodule
